// File: rtl/player_countdown_timer_pkg.sv
// ---------------------------------------------------------------------------
// chess_timer_pkg
// Shared types and constants for the per-player chess clock.
//   bcd_t            : one BCD digit (4 bits)
//   SEG_0 .. SEG_9   : active-low seven-segment patterns, bit0=a ... bit6=g
//   SEG_BLANK        : all segments off
//   MAX_MINS/MAX_TENS: largest legal minutes / tens-of-seconds digit
// ---------------------------------------------------------------------------
package chess_timer_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam bcd_t       MAX_MINS  = 4'd9;
    localparam logic [2:0] MAX_TENS  = 3'd5;

endpackage

// File: rtl/seg7_decoder.sv
// ---------------------------------------------------------------------------
// seg7_decoder
// Combinational BCD to active-low seven-segment decoder.
//   digit_i : BCD digit (codes 10-15 decode to blank)
//   seg_o   : active-low segments, bit0=a ... bit6=g
// ---------------------------------------------------------------------------
module seg7_decoder
    import chess_timer_pkg::*;
(
    input  bcd_t       digit_i,
    output logic [6:0] seg_o
);

    // Digit lookup; out-of-range codes blank the digit.
    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/player_countdown_timer.sv
// ---------------------------------------------------------------------------
// player_countdown_timer
// One player's chess clock: counts M:SS down from START_MINS:00 while flag is
// high, shows it on three active-low seven-segment digits and raises a sticky
// Timeout when 0:00 is reached.
//
// Parameters:
//   CLOCK_FREQ : clock cycles per second (>= 2)
//   START_MINS : minutes loaded at reset (1..9)
//   INC_SECS   : Fischer increment in seconds (0..59), increment build only
//
// Ports:
//   clock       in   system clock
//   reset       in   synchronous active-high reset
//   flag        in   run enable for this player
//   SegMins     out  minutes digit, active-low
//   SegSecTens  out  tens-of-seconds digit, active-low
//   SegSecUnits out  units-of-seconds digit, active-low
//   Timeout     out  sticky, high once the time reaches 0:00
//
// Build option: define TIMER_INCREMENT_EN to add INC_SECS (saturating at
// 9:59) whenever flag falls while the clock has not timed out.
// ---------------------------------------------------------------------------
module player_countdown_timer
    import chess_timer_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int START_MINS = 5,
    parameter int INC_SECS   = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       flag,
    output logic [6:0] SegMins,
    output logic [6:0] SegSecTens,
    output logic [6:0] SegSecUnits,
    output logic       Timeout
);

    localparam int             PW         = $clog2(CLOCK_FREQ);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(CLOCK_FREQ - 1);
    localparam bcd_t           START_BCD  = 4'(START_MINS);

    bcd_t          mins_q,  mins_d;
    logic [2:0]    tens_q,  tens_d;
    bcd_t          units_q, units_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          timeout_q, timeout_d;

    logic          run_s;
    logic          tick_s;
    logic          fall_s;

    bcd_t          dec_mins_s;
    logic [2:0]    dec_tens_s;
    bcd_t          dec_units_s;
    logic          dec_zero_s;

    bcd_t          inc_mins_s;
    logic [2:0]    inc_tens_s;
    bcd_t          inc_units_s;

    // Prescaler: advances only while running so a pause keeps the partial second.
    always_comb begin
        run_s   = flag & ~timeout_q;
        tick_s  = 1'b0;
        presc_d = presc_q;
        if (run_s) begin
            if (presc_q == PRESC_LAST) begin
                tick_s  = 1'b1;
                presc_d = '0;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end else begin
            presc_d = presc_q;
        end
    end

    // One-second BCD decrement with borrow from units to tens to minutes.
    always_comb begin
        dec_mins_s  = mins_q;
        dec_tens_s  = tens_q;
        dec_units_s = units_q;
        if (units_q != 4'd0) begin
            dec_units_s = units_q - 4'd1;
        end else begin
            dec_units_s = 4'd9;
            if (tens_q != 3'd0) begin
                dec_tens_s = tens_q - 3'd1;
            end else begin
                dec_tens_s = MAX_TENS;
                dec_mins_s = mins_q - 4'd1;
            end
        end
        dec_zero_s = (dec_mins_s == 4'd0) && (dec_tens_s == 3'd0) && (dec_units_s == 4'd0);
    end

`ifdef TIMER_INCREMENT_EN
    localparam int INC_U = INC_SECS % 10;
    localparam int INC_T = INC_SECS / 10;

    logic       flag_q;
    logic [4:0] u_sum_s;
    logic [3:0] t_sum_s;
    logic [4:0] m_sum_s;
    logic       carry_u_s;
    logic       carry_t_s;

    // Falling edge of flag marks the end of this player's turn.
    always_comb begin
        fall_s = flag_q & ~flag & ~timeout_q;
    end

    // BCD add of INC_SECS; anything past 9:59 clamps to 9:59.
    always_comb begin
        u_sum_s   = {1'b0, units_q} + 5'(INC_U);
        carry_u_s = 1'b0;
        carry_t_s = 1'b0;
        if (u_sum_s >= 5'd10) begin
            inc_units_s = 4'(u_sum_s - 5'd10);
            carry_u_s   = 1'b1;
        end else begin
            inc_units_s = u_sum_s[3:0];
        end
        t_sum_s = {1'b0, tens_q} + 4'(INC_T) + {3'b000, carry_u_s};
        if (t_sum_s >= 4'd6) begin
            inc_tens_s = 3'(t_sum_s - 4'd6);
            carry_t_s  = 1'b1;
        end else begin
            inc_tens_s = t_sum_s[2:0];
        end
        m_sum_s = {1'b0, mins_q} + {4'b0000, carry_t_s};
        if (m_sum_s > {1'b0, MAX_MINS}) begin
            inc_mins_s  = MAX_MINS;
            inc_tens_s  = MAX_TENS;
            inc_units_s = 4'd9;
        end else begin
            inc_mins_s  = m_sum_s[3:0];
        end
    end

    // Previous flag value for edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag;
        end
    end
`else
    // Without the increment feature the time only ever counts down.
    always_comb begin
        fall_s      = 1'b0;
        inc_mins_s  = mins_q;
        inc_tens_s  = tens_q;
        inc_units_s = units_q;
    end
`endif

    // Next time/timeout selection; after timeout everything freezes.
    always_comb begin
        mins_d    = mins_q;
        tens_d    = tens_q;
        units_d   = units_q;
        timeout_d = timeout_q;
        if (timeout_q) begin
            timeout_d = 1'b1;
        end else if (tick_s) begin
            mins_d    = dec_mins_s;
            tens_d    = dec_tens_s;
            units_d   = dec_units_s;
            timeout_d = dec_zero_s;
        end else if (fall_s) begin
            mins_d    = inc_mins_s;
            tens_d    = inc_tens_s;
            units_d   = inc_units_s;
        end else begin
            timeout_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            mins_q    <= START_BCD;
            tens_q    <= 3'd0;
            units_q   <= 4'd0;
            presc_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            mins_q    <= mins_d;
            tens_q    <= tens_d;
            units_q   <= units_d;
            presc_q   <= presc_d;
            timeout_q <= timeout_d;
        end
    end

    seg7_decoder u_dec_mins (
        .digit_i (mins_q),
        .seg_o   (SegMins)
    );

    seg7_decoder u_dec_tens (
        .digit_i ({1'b0, tens_q}),
        .seg_o   (SegSecTens)
    );

    seg7_decoder u_dec_units (
        .digit_i (units_q),
        .seg_o   (SegSecUnits)
    );

    assign Timeout = timeout_q;

endmodule

// File: tb/tb_player_countdown_timer.sv
// ---------------------------------------------------------------------------
// tb_player_countdown_timer
// Table-driven vectors plus randomized flag/reset traffic for the chess clock,
// checked against a seconds-count reference model.
// ---------------------------------------------------------------------------
module tb_player_countdown_timer;

    localparam int CF  = 4;
    localparam int SM  = 1;
    localparam int INC = 2;

    logic       clock;
    logic       reset;
    logic       flag;
    logic [6:0] seg_m, seg_t, seg_u;
    logic       tmo;

    int total_cnt = 0;
    int bad_cnt   = 0;

    typedef struct {
        int secs;
        int cnt;
        bit to;
        bit fq;
    } model_t;

    typedef struct {
        bit rst;
        bit flg;
        int cycles;
        int em;
        int et;
        int eu;
        bit eto;
    } vec_t;

    model_t m;
    vec_t   vec[20];

    player_countdown_timer #(
        .CLOCK_FREQ (CF),
        .START_MINS (SM),
        .INC_SECS   (INC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .flag        (flag),
        .SegMins     (seg_m),
        .SegSecTens  (seg_t),
        .SegSecUnits (seg_u),
        .Timeout     (tmo)
    );

`ifdef TIMER_INCREMENT_EN
    logic       reset9;
    logic       flag9;
    logic [6:0] seg9_m, seg9_t, seg9_u;
    logic       tmo9;
    model_t     m9;

    player_countdown_timer #(
        .CLOCK_FREQ (CF),
        .START_MINS (9),
        .INC_SECS   (INC)
    ) dut9 (
        .clock       (clock),
        .reset       (reset9),
        .flag        (flag9),
        .SegMins     (seg9_m),
        .SegSecTens  (seg9_t),
        .SegSecUnits (seg9_u),
        .Timeout     (tmo9)
    );
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Reference: time kept as plain seconds remaining, prescaler as a count.
    function automatic model_t model_step(input model_t p, input bit r, input bit f,
                                          input int start);
        model_t n;
        n = p;
        if (r) begin
            n.secs = start * 60;
            n.cnt  = 0;
            n.to   = 1'b0;
            n.fq   = 1'b0;
        end else begin
            if (f && !p.to) begin
                n.cnt = p.cnt + 1;
                if (n.cnt == CF) begin
                    n.cnt  = 0;
                    n.secs = p.secs - 1;
                    if (n.secs == 0) n.to = 1'b1;
                end
            end
`ifdef TIMER_INCREMENT_EN
            if (p.fq && !f && !p.to) n.secs = (p.secs + INC > 599) ? 599 : p.secs + INC;
`endif
            n.fq = f;
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_time(input string tag, input logic [6:0] gm, input logic [6:0] gt,
                              input logic [6:0] gu, input logic gto, input int secs,
                              input bit to);
        check({tag, " mins"},  gm, seg_of(secs / 60));
        check({tag, " tens"},  gt, seg_of((secs % 60) / 10));
        check({tag, " units"}, gu, seg_of(secs % 10));
        check({tag, " timeout"}, {6'b0, gto}, {6'b0, to});
    endtask

    task automatic step(input bit r, input bit f);
        reset = r;
        flag  = f;
        @(posedge clock);
        m = model_step(m, r, f, SM);
        #1;
        check_time("model", seg_m, seg_t, seg_u, tmo, m.secs, m.to);
    endtask

`ifdef TIMER_INCREMENT_EN
    task automatic step9(input bit r, input bit f);
        reset9 = r;
        flag9  = f;
        @(posedge clock);
        m9 = model_step(m9, r, f, 9);
        #1;
        check_time("model9", seg9_m, seg9_t, seg9_u, tmo9, m9.secs, m9.to);
    endtask
`endif

    initial begin
        reset = 1'b1;
        flag  = 1'b0;
        m     = '{secs: 0, cnt: 0, to: 1'b0, fq: 1'b0};
`ifdef TIMER_INCREMENT_EN
        reset9 = 1'b1;
        flag9  = 1'b0;
        m9     = '{secs: 0, cnt: 0, to: 1'b0, fq: 1'b0};
`endif

        // reset + idle, first tick, pause, full timeout, reset mid-run
        vec[0]  = '{1'b1, 1'b0,   1, 1, 0, 0, 1'b0};
        vec[1]  = '{1'b0, 1'b0,  20, 1, 0, 0, 1'b0};
        vec[2]  = '{1'b0, 1'b1,   3, 1, 0, 0, 1'b0};
        vec[3]  = '{1'b0, 1'b1,   1, 0, 5, 9, 1'b0};
        vec[4]  = '{1'b1, 1'b0,   1, 1, 0, 0, 1'b0};
        vec[5]  = '{1'b0, 1'b1,   2, 1, 0, 0, 1'b0};
`ifdef TIMER_INCREMENT_EN
        vec[6]  = '{1'b0, 1'b0,  10, 1, 0, 2, 1'b0};
        vec[7]  = '{1'b0, 1'b1,   1, 1, 0, 2, 1'b0};
        vec[8]  = '{1'b0, 1'b1,   1, 1, 0, 1, 1'b0};
`else
        vec[6]  = '{1'b0, 1'b0,  10, 1, 0, 0, 1'b0};
        vec[7]  = '{1'b0, 1'b1,   1, 1, 0, 0, 1'b0};
        vec[8]  = '{1'b0, 1'b1,   1, 0, 5, 9, 1'b0};
`endif
        vec[9]  = '{1'b1, 1'b0,   1, 1, 0, 0, 1'b0};
        vec[10] = '{1'b0, 1'b1, 239, 0, 0, 1, 1'b0};
        vec[11] = '{1'b0, 1'b1,   1, 0, 0, 0, 1'b1};
        vec[12] = '{1'b0, 1'b1,  50, 0, 0, 0, 1'b1};
        vec[13] = '{1'b0, 1'b0,   1, 0, 0, 0, 1'b1};
        vec[14] = '{1'b1, 1'b0,   1, 1, 0, 0, 1'b0};
        vec[15] = '{1'b0, 1'b1,  92, 0, 3, 7, 1'b0};
        vec[16] = '{1'b0, 1'b1,   2, 0, 3, 7, 1'b0};
        vec[17] = '{1'b1, 1'b1,   1, 1, 0, 0, 1'b0};
        vec[18] = '{1'b0, 1'b1,   3, 1, 0, 0, 1'b0};
        vec[19] = '{1'b0, 1'b1,   1, 0, 5, 9, 1'b0};

        for (int i = 0; i < 20; i++) begin
            for (int c = 0; c < vec[i].cycles; c++) step(vec[i].rst, vec[i].flg);
            check($sformatf("vec%0d mins", i),  seg_m, seg_of(vec[i].em));
            check($sformatf("vec%0d tens", i),  seg_t, seg_of(vec[i].et));
            check($sformatf("vec%0d units", i), seg_u, seg_of(vec[i].eu));
            check($sformatf("vec%0d timeout", i), {6'b0, tmo}, {6'b0, vec[i].eto});
        end

`ifdef TIMER_INCREMENT_EN
        // 0:59 then end of turn gives 1:01
        step(1'b1, 1'b0);
        for (int c = 0; c < CF; c++) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        check("inc 0:59+2 mins",  seg_m, seg_of(1));
        check("inc 0:59+2 tens",  seg_t, seg_of(0));
        check("inc 0:59+2 units", seg_u, seg_of(1));
`endif

        // randomized turns with occasional resets
        step(1'b1, 1'b0);
        for (int c = 0; c < 1500; c++) begin
            step($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0);
        end

`ifdef TIMER_INCREMENT_EN
        // repeated short turns from 9:00 drive the clock into 9:59 saturation
        step9(1'b1, 1'b0);
        for (int c = 0; c < 40; c++) begin
            step9(1'b0, 1'b1);
            step9(1'b0, 1'b0);
        end
        check("sat mins",  seg9_m, seg_of(9));
        check("sat tens",  seg9_t, seg_of(5));
        check("sat units", seg9_u, seg_of(9));
`endif

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
